// File: rtl/pool_out_writer_if.sv
// Write bus between the pooled-pixel writer and the output feature-map SRAM.
// The writer drives request, address and packed data; the SRAM returns ready.
interface pool_out_writer_if #(
  parameter int DATA_W = 16,
  parameter int PACK   = 2,
  parameter int ADDR_W = 8
);
  logic                     mem_wr_en;
  logic [ADDR_W-1:0]        mem_addr;
  logic [PACK*DATA_W-1:0]   mem_wdata;
  logic                     mem_ready;

  modport master (output mem_wr_en, output mem_addr, output mem_wdata, input mem_ready);
  modport slave  (input mem_wr_en, input mem_addr, input mem_wdata, output mem_ready);
endinterface

// File: rtl/pool_out_writer.sv
// Pooled-pixel writer: buffers pixels from the max-pooling stage in a small
// FIFO, packs PACK pixels per SRAM word (pixel 0 in the LSBs) and writes the
// words to row-major addresses starting at the frame base. A frame is armed by
// start and closed by pooling_finish with a single frame_done pulse.
module pool_out_writer #(
  parameter int DATA_W     = 16,
  parameter int OUT_W      = 14,
  parameter int OUT_H      = 14,
  parameter int PACK       = 2,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              pool_done_i,
  input  logic [DATA_W-1:0] pool_data_i,
  input  logic              pooling_finish_i,
  pool_out_writer_if.master mem,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              overflow_err_o,
  output logic              short_frame_err_o
);

  localparam int TOTAL  = OUT_W * OUT_H;
  localparam int CNT_W  = $clog2(TOTAL + 1);
  localparam int COL_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WORD_W = PACK * DATA_W;

  localparam logic [CNT_W-1:0]  TOTAL_C   = CNT_W'(TOTAL);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(OUT_W - 1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PACK - 1);
  localparam logic [PTR_W:0]    FILL_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  // Pixel FIFO
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    fill_q, fill_d;

  // Frame counters and packer
  logic [CNT_W-1:0]  cnt_q, cnt_d;     // pixels accepted into this frame
  logic [COL_W-1:0]  col_q;            // column of the next pixel to pack
  logic [LANE_W-1:0] lane_q;           // lane of the next pixel to pack
  logic [WORD_W-1:0] acc_q, acc_next;  // partially packed word
  logic [ADDR_W-1:0] waddr_q;          // address of the word being packed

  // Closed word waiting for the SRAM
  logic [WORD_W-1:0] wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic              pend_q, pend_d;

  logic ovf_q, short_q;

  logic fifo_empty, fifo_full, word_free, push_req, push, pop;
  logic close, flush, load, arm, enter_drain;

  // Datapath handshakes: FIFO push/pop, word closing and the pending-write flag.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can leave a latch behind.
    acc_next   = acc_q;
    fifo_empty = (fill_q == '0);
    fifo_full  = (fill_q == FILL_FULL);
    word_free  = !pend_q || mem.mem_ready;
    pop        = !fifo_empty && word_free;
    push_req   = (state_q == S_COLLECT) && pool_done_i;
    push       = push_req && (cnt_q != TOTAL_C) && (!fifo_full || pop);
    close      = (lane_q == LANE_LAST) || (col_q == COL_LAST);
    flush      = (state_q == S_DRAIN) && fifo_empty && (lane_q != '0) && word_free;
    load       = (pop && close) || flush;
    if (pop) acc_next[int'(lane_q)*DATA_W +: DATA_W] = fifo_mem[rd_ptr_q];
    cnt_d      = push ? cnt_q + CNT_W'(1) : cnt_q;
    fill_d     = fill_q;
    if (push && !pop)      fill_d = fill_q + (PTR_W + 1)'(1);
    else if (!push && pop) fill_d = fill_q - (PTR_W + 1)'(1);
    if (load)                fill_d = fill_d;
    pend_d     = pend_q;
    if (load)                pend_d = 1'b1;
    else if (mem.mem_ready)  pend_d = 1'b0;
  end

  // Frame sequencing: next state and the state-decoded status outputs.
  always_comb begin
    state_d      = state_q;
    arm          = 1'b0;
    enter_drain  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_COLLECT;
          arm     = 1'b1;
        end
      end
      S_COLLECT: begin
        if (pooling_finish_i) begin
          state_d     = S_DRAIN;
          enter_drain = 1'b1;
        end
      end
      S_DRAIN: begin
        if (fifo_empty && (lane_q == '0) && !pend_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_o       = (state_q == S_COLLECT) || (state_q == S_DRAIN);
    frame_done_o = (state_q == S_DONE);
  end

  assign mem.mem_wr_en      = pend_q;
  assign mem.mem_addr       = addr_q;
  assign mem.mem_wdata      = wdata_q;
  assign overflow_err_o     = ovf_q;
  assign short_frame_err_o  = short_q;

  // FIFO storage: written on an accepted push, read through rd_ptr_q.
  // NOTE: the storage array has no reset; the pointers and fill count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= pool_data_i;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Pointers, counters, packer, word register and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      col_q    <= '0;
      lane_q   <= '0;
      acc_q    <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        col_q    <= (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
      end
      if (load) begin
        wdata_q <= acc_next;
        addr_q  <= waddr_q;
        waddr_q <= waddr_q + ADDR_W'(1);
        acc_q   <= '0;
        lane_q  <= '0;
      end else if (pop) begin
        acc_q  <= acc_next;
        lane_q <= lane_q + LANE_W'(1);
      end
      if (push_req && !push) ovf_q <= 1'b1;
      if (enter_drain && (cnt_d < TOTAL_C)) short_q <= 1'b1;
      if (arm) begin
        cnt_q   <= '0;
        col_q   <= '0;
        lane_q  <= '0;
        acc_q   <= '0;
        waddr_q <= base_addr_i;
        ovf_q   <= 1'b0;
        short_q <= 1'b0;
      end
    end
  end

endmodule
